// File: rtl/score_pkg.sv
// Shared definitions for the score sequencer: keyboard command codes,
// FSM state encoding, decoded-command payload and a note-format helper.
package score_pkg;

  localparam int unsigned CMD_W = 5;

  localparam logic [CMD_W-1:0] CMD_PLAY    = 5'b10000;
  localparam logic [CMD_W-1:0] CMD_PAUSE   = 5'b10001;
  localparam logic [CMD_W-1:0] CMD_STOP    = 5'b10010;
  localparam logic [CMD_W-1:0] CMD_NEXT    = 5'b10011;
  localparam logic [2:0]       CMD_SEL_PFX = 3'b101;
  localparam logic [CMD_W-1:0] CMD_LOOP    = 5'b11000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // One-hot decoded keyboard command; all zero when no valid/known command.
  typedef struct packed {
    logic play;
    logic pause;
    logic stop;
    logic advance;
    logic sel;
    logic loop;
  } cmd_dec_t;

  // Bit index of the valid flag inside a note word.
  function automatic int unsigned note_valid_idx(input int unsigned note_w);
    return note_w - 1;
  endfunction

  // Decode a raw command code; undefined codes decode to all zero.
  function automatic cmd_dec_t decode_cmd(input logic valid,
                                          input logic [CMD_W-1:0] code);
    cmd_dec_t d;
    d = '0;
    if (valid) begin
      d.play    = (code == CMD_PLAY);
      d.pause   = (code == CMD_PAUSE);
      d.stop    = (code == CMD_STOP);
      d.advance = (code == CMD_NEXT);
      d.sel     = (code[CMD_W-1 -: 3] == CMD_SEL_PFX);
      d.loop    = (code == CMD_LOOP);
    end
    return d;
  endfunction

endpackage

// File: rtl/beat_divider.sv
// Beat-rate divider: counts 0..DIV-1 while enabled and flags the last count.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : count enable (holds value when low)
//   clr          : synchronous clear, wins over en
//   tick         : high while enabled and the count is DIV-1
module beat_divider #(
  parameter int unsigned DIV = 32768
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Decode of the registered count; the sequencer needs it in the same cycle.
  assign tick = en && (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/score_sequencer.sv
// Score playback controller: walks one song region of an external
// synchronous score ROM at a beat rate under keyboard commands and
// forwards the current note to the tone generator.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   cmd_valid    : one-cycle strobe qualifying cmd
//   cmd          : keyboard command code
//   rom_data     : ROM read data, one cycle after rom_addr
//   rom_addr     : {song, step}
//   note_out     : current note, 0 when not playing
//   playing      : high in PLAY
//   song_end     : one-cycle pulse at end of song
//   loop_en      : loop mode flag
//   step_dbg     : current step
//   beat_dbg     : beat tick, delayed one cycle
module score_sequencer
  import score_pkg::*;
#(
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned STEP_BITS = 5,
  parameter int unsigned NOTE_W    = 8,
  parameter int unsigned BEAT_DIV  = 32768,
  parameter int unsigned DEF_SONG  = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           cmd_valid,
  input  logic [CMD_W-1:0]               cmd,
  input  logic [NOTE_W-1:0]              rom_data,
  output logic [SONG_BITS+STEP_BITS-1:0] rom_addr,
  output logic [NOTE_W-1:0]              note_out,
  output logic                           playing,
  output logic                           song_end,
  output logic                           loop_en,
  output logic [STEP_BITS-1:0]           step_dbg,
  output logic                           beat_dbg
);

  localparam int unsigned ADDR_W    = SONG_BITS + STEP_BITS;
  localparam int unsigned VALID_BIT = note_valid_idx(NOTE_W);
  localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'((1 << STEP_BITS) - 1);

  state_e                state, state_nxt;
  logic [SONG_BITS-1:0]  song, song_nxt;
  logic [STEP_BITS-1:0]  step, step_nxt;
  logic                  loop_nxt;
  logic                  song_end_nxt;
  logic [NOTE_W-1:0]     note_nxt;
  logic                  rd_ok, rd_ok_nxt;
  logic                  tick;
  logic                  end_c;
  logic                  leave_c;
  logic [SONG_BITS-1:0]  cmd_song;
  cmd_dec_t              dec;

  assign dec     = decode_cmd(cmd_valid, cmd);
  assign leave_c = dec.stop | dec.sel | dec.advance;
  assign cmd_song = dec.sel ? SONG_BITS'(cmd[1:0]) : song + SONG_BITS'(1);

  // rd_ok: rom_data belongs to the current rom_addr and was read while playing.
  assign end_c = (state == ST_PLAY) &&
                 ((rd_ok && !rom_data[VALID_BIT]) || (step == LAST_STEP && tick));

  // Divider is held at zero in IDLE so the first beat after PLAY is full length.
  beat_divider #(
    .DIV (BEAT_DIV)
  ) u_beat_divider (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == ST_PLAY),
    .clr     ((state == ST_IDLE) || end_c),
    .tick    (tick)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt    = state;
    song_nxt     = song;
    step_nxt     = step;
    loop_nxt     = loop_en;
    song_end_nxt = 1'b0;
    note_nxt     = note_out;
    rd_ok_nxt    = 1'b0;

    // Loop toggle is honoured even in the end-of-song cycle.
    if (dec.loop) begin
      loop_nxt = ~loop_en;
    end

    if (end_c) begin
      song_end_nxt = 1'b1;
      step_nxt     = '0;
      state_nxt    = loop_en ? ST_PLAY : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dec.play) begin
            state_nxt = ST_PLAY;
          end else if (dec.sel || dec.advance) begin
            song_nxt = cmd_song;
            step_nxt = '0;
          end
        end
        ST_PLAY: begin
          if (dec.pause) begin
            state_nxt = ST_PAUSE;
          end else if (leave_c) begin
            state_nxt = ST_IDLE;
            step_nxt  = '0;
            if (dec.sel || dec.advance) begin
              song_nxt = cmd_song;
            end
          end else if (tick) begin
            step_nxt = step + STEP_BITS'(1);
          end
        end
        ST_PAUSE: begin
          if (dec.play) begin
            state_nxt = ST_PLAY;
          end else if (leave_c) begin
            state_nxt = ST_IDLE;
            step_nxt  = '0;
            if (dec.sel || dec.advance) begin
              song_nxt = cmd_song;
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    rd_ok_nxt = (state == ST_PLAY) && (state_nxt == ST_PLAY) &&
                ({song_nxt, step_nxt} == rom_addr);

    // Only valid notes read back for the current address reach the output.
    if (state_nxt != ST_PLAY) begin
      note_nxt = '0;
    end else if ((state == ST_PLAY) && rd_ok && rom_data[VALID_BIT]) begin
      note_nxt = rom_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      song     <= SONG_BITS'(DEF_SONG);
      step     <= '0;
      loop_en  <= 1'b0;
      rom_addr <= ADDR_W'({SONG_BITS'(DEF_SONG), STEP_BITS'(0)});
      note_out <= '0;
      playing  <= 1'b0;
      song_end <= 1'b0;
      beat_dbg <= 1'b0;
      rd_ok    <= 1'b0;
    end else begin
      state    <= state_nxt;
      song     <= song_nxt;
      step     <= step_nxt;
      loop_en  <= loop_nxt;
      rom_addr <= {song_nxt, step_nxt};
      note_out <= note_nxt;
      playing  <= (state_nxt == ST_PLAY);
      song_end <= song_end_nxt;
      beat_dbg <= tick;
      rd_ok    <= rd_ok_nxt;
    end
  end

  assign step_dbg = step;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed testbench for score_sequencer with a 4-cycle beat and a
// behavioural synchronous score ROM.
module tb_score_sequencer;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic [4:0] cmd;
  logic [7:0] rom_data = 8'h00;
  logic [6:0] rom_addr;
  logic [7:0] note_out;
  logic       playing;
  logic       song_end;
  logic       loop_en;
  logic [4:0] step_dbg;
  logic       beat_dbg;

  logic [7:0] rom [128];

  int n_run  = 0;
  int n_fail = 0;

  int t1_note [16] = '{'h00, 'h00, 'h81, 'h81, 'h81, 'h81, 'h82, 'h82,
                       'h82, 'h82, 'h83, 'h83, 'h83, 'h83, 'h00, 'h00};
  int t1_addr [16] = '{'h20, 'h20, 'h20, 'h20, 'h21, 'h21, 'h21, 'h21,
                       'h22, 'h22, 'h22, 'h22, 'h23, 'h23, 'h20, 'h20};
  int t2_note [19] = '{'h00, 'h00, 'h81, 'h81, 'h81, 'h81, 'h82, 'h82, 'h82, 'h82,
                       'h83, 'h83, 'h83, 'h83, 'h83, 'h83, 'h81, 'h81, 'h81};
  int t2_addr [19] = '{'h20, 'h20, 'h20, 'h20, 'h21, 'h21, 'h21, 'h21, 'h22, 'h22,
                       'h22, 'h22, 'h23, 'h23, 'h20, 'h20, 'h20, 'h20, 'h21};

  score_sequencer #(
    .SONG_BITS (2),
    .STEP_BITS (5),
    .NOTE_W    (8),
    .BEAT_DIV  (4),
    .DEF_SONG  (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .rom_data  (rom_data),
    .rom_addr  (rom_addr),
    .note_out  (note_out),
    .playing   (playing),
    .song_end  (song_end),
    .loop_en   (loop_en),
    .step_dbg  (step_dbg),
    .beat_dbg  (beat_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a command for one cycle, starting and ending on a falling edge.
  task automatic send(input logic [4:0] c);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd       = 5'b00000;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    rom[7'h00] = 8'h85; rom[7'h01] = 8'h86;
    rom[7'h20] = 8'h81; rom[7'h21] = 8'h82; rom[7'h22] = 8'h83;
    for (int i = 0; i < 32; i++) rom[64 + i] = 8'(8'h80 + i);
    rom[7'h60] = 8'h8A;

    cmd_valid = 1'b0;
    cmd       = 5'b00000;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst playing", playing, 0);
    chk("rst note", note_out, 0);
    chk("rst addr", rom_addr, 'h20);
    chk("rst loop", loop_en, 0);
    chk("rst step", step_dbg, 0);
    chk("rst end", song_end, 0);

    // Song 1 played once, loop off.
    send(5'b10000);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t1 note c%0d", k), note_out, t1_note[k]);
      chk($sformatf("t1 addr c%0d", k), rom_addr, t1_addr[k]);
      chk($sformatf("t1 playing c%0d", k), playing, (k < 14));
      chk($sformatf("t1 song_end c%0d", k), song_end, (k == 14));
      chk($sformatf("t1 beat c%0d", k), beat_dbg, (k == 4 || k == 8 || k == 12));
      @(negedge clk);
    end

    // Song 1 with loop mode.
    send(5'b11000);
    chk("t2 loop on", loop_en, 1);
    send(5'b10000);
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("t2 note c%0d", k), note_out, t2_note[k]);
      chk($sformatf("t2 addr c%0d", k), rom_addr, t2_addr[k]);
      chk($sformatf("t2 playing c%0d", k), playing, 1);
      chk($sformatf("t2 song_end c%0d", k), song_end, (k == 14));
      @(negedge clk);
    end
    send(5'b10010);
    send(5'b11000);
    chk("t2 loop off", loop_en, 0);
    chk("t2 stop playing", playing, 0);
    chk("t2 stop addr", rom_addr, 'h20);

    // Pause mid-beat on step 2, then resume.
    send(5'b10000);
    repeat (9) @(negedge clk);
    chk("t3 pre-pause step", step_dbg, 2);
    send(5'b10001);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t3 pause step p%0d", k), step_dbg, 2);
      chk($sformatf("t3 pause playing p%0d", k), playing, 0);
      chk($sformatf("t3 pause note p%0d", k), note_out, 0);
      @(negedge clk);
    end
    send(5'b10000);
    chk("t3 r0 step", step_dbg, 2);
    chk("t3 r0 playing", playing, 1);
    @(negedge clk);
    chk("t3 r1 step", step_dbg, 2);
    chk("t3 r1 note", note_out, 0);
    @(negedge clk);
    chk("t3 r2 step", step_dbg, 3);
    chk("t3 r2 note", note_out, 'h83);
    @(negedge clk);
    chk("t3 r3 end", song_end, 0);
    chk("t3 r3 note", note_out, 'h83);
    @(negedge clk);
    chk("t3 r4 end", song_end, 1);
    chk("t3 r4 playing", playing, 0);
    chk("t3 r4 note", note_out, 0);

    // Song selection and NEXT wrap.
    send(5'b10000);
    repeat (6) @(negedge clk);
    chk("t4 note", note_out, 'h82);
    chk("t4 addr", rom_addr, 'h21);
    send(5'b10111);
    chk("t4 sel playing", playing, 0);
    chk("t4 sel note", note_out, 0);
    chk("t4 sel addr", rom_addr, 'h60);
    chk("t4 sel step", step_dbg, 0);
    send(5'b01111);
    chk("t4 undef addr", rom_addr, 'h60);
    chk("t4 undef playing", playing, 0);
    send(5'b10011);
    chk("t4 next wrap", rom_addr, 'h00);
    send(5'b10011);
    chk("t4 next", rom_addr, 'h20);
    send(5'b10000);
    repeat (2) @(negedge clk);
    send(5'b10011);
    chk("t4 next in play addr", rom_addr, 'h40);
    chk("t4 next in play playing", playing, 0);
    chk("t4 next in play note", note_out, 0);

    // Full 32-step song, loop off.
    send(5'b10000);
    repeat (2) @(negedge clk);
    chk("t5 c2 note", note_out, 'h80);
    repeat (4) @(negedge clk);
    chk("t5 c6 note", note_out, 'h81);
    repeat (120) @(negedge clk);
    chk("t5 c126 note", note_out, 'h9F);
    chk("t5 c126 addr", rom_addr, 'h5F);
    @(negedge clk);
    chk("t5 c127 step", step_dbg, 31);
    chk("t5 c127 playing", playing, 1);
    chk("t5 c127 end", song_end, 0);
    @(negedge clk);
    chk("t5 c128 end", song_end, 1);
    chk("t5 c128 playing", playing, 0);
    chk("t5 c128 step", step_dbg, 0);
    chk("t5 c128 addr", rom_addr, 'h40);
    chk("t5 c128 note", note_out, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t5 idle note %0d", k), note_out, 0);
      chk($sformatf("t5 idle end %0d", k), song_end, 0);
    end

    // Asynchronous reset mid-play.
    send(5'b10101);
    chk("t6 sel1 addr", rom_addr, 'h20);
    send(5'b11000);
    chk("t6 loop on", loop_en, 1);
    send(5'b10000);
    repeat (5) @(negedge clk);
    chk("t6 pre playing", playing, 1);
    chk("t6 pre addr", rom_addr, 'h21);
    #2 reset_n = 1'b0;
    #1;
    chk("t6 async playing", playing, 0);
    chk("t6 async note", note_out, 0);
    chk("t6 async addr", rom_addr, 'h20);
    chk("t6 async loop", loop_en, 0);
    chk("t6 async step", step_dbg, 0);
    chk("t6 async end", song_end, 0);
    chk("t6 async beat", beat_dbg, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6 post playing", playing, 0);
    chk("t6 post loop", loop_en, 0);
    chk("t6 post addr", rom_addr, 'h20);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/score_sequencer.md
Name: score_sequencer

Overview:
- Parametrised score playback controller. Generalises the fixed 4-song / 32-step score reader.
- Steps through one song region of an external synchronous score ROM at a beat rate, under keyboard commands.
- Forwards the current note to the tone generator.
- Adds over the previous block: N songs, configurable depth and beat rate, loop mode, next-song command, end-of-song pulse, and a registered command strobe.

Parameters:
- SONG_BITS, 2, log2 of song count; songs occupy the ROM address MSBs.
- STEP_BITS, 5, log2 of steps per song; step counter width.
- NOTE_W, 8, note word width; bit NOTE_W-1 = valid flag, lower bits = pitch code.
- BEAT_DIV, 32768, clk cycles per beat (>=4).
- DEF_SONG, 1, song selected out of reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  one-cycle strobe: cmd is valid
- cmd  in  5  keyboard command code
- rom_data  in  NOTE_W  ROM read data, 1-cycle latency after rom_addr
- rom_addr  out  SONG_BITS+STEP_BITS  {song, step}, registered
- note_out  out  NOTE_W  current note; 0 when not playing
- playing  out  1  1 in PLAY state
- song_end  out  1  one-cycle pulse at end of song
- loop_en  out  1  loop mode flag
- step_dbg  out  STEP_BITS  current step
- beat_dbg  out  1  beat tick

Behaviour:
- Reset (async): state=IDLE, song=DEF_SONG, step=0, loop_en=0, divider=0, all other outputs 0.
- Commands are sampled only when cmd_valid=1. Undefined codes are ignored. Codes:
  - PLAY=10000
  - PAUSE=10001
  - STOP=10010
  - NEXT=10011
  - SEL=101ss (ss = song index, zero-extended or truncated to SONG_BITS)
  - LOOP_TOGGLE=11000
- States: IDLE, PLAY, PAUSE.
- IDLE:
  - PLAY -> PLAY.
  - SEL / NEXT: change song, step=0, stay IDLE.
  - LOOP_TOGGLE flips loop_en in any state.
- PLAY:
  - Divider counts 0..BEAT_DIV-1; beat tick when divider = BEAT_DIV-1.
  - On tick, step++.
  - PAUSE -> PAUSE; step and divider hold.
  - STOP -> IDLE, step=0.
  - SEL / NEXT -> IDLE, step=0, new song.
- PAUSE:
  - PLAY -> PLAY; divider resumes from its held value.
  - STOP / SEL / NEXT behave as in PLAY.
- Divider is cleared on IDLE->PLAY, so the first note lasts a full beat.
- NEXT: song = song+1, wrapping 2^SONG_BITS-1 -> 0.
- rom_addr is registered {song, step} and updates the cycle after step/song changes.
- note_out:
  - Registered from rom_data in PLAY: 2-cycle latency from step change to note_out.
  - Forced to 0 the cycle after leaving PLAY.
- End of song, evaluated in PLAY only. Condition: rom_data valid bit = 0 with rom_addr stable for at least 1 cycle, OR (step = 2^STEP_BITS-1 AND beat tick).
  - Both cases: song_end pulses 1 cycle, step=0, divider=0.
  - loop_en=1: remain PLAY.
  - loop_en=0: -> IDLE.
  - The zero note is never driven on note_out.
- Priority in one cycle: reset > end-of-song > command > beat tick. A command in the end cycle is dropped, except LOOP_TOGGLE, which is still applied.
- PLAY command while already in PLAY: no effect.
- SEL of the current song: still restarts at step 0 and -> IDLE.
- Reset mid-song: immediate return to reset values; no song_end pulse.

Decomposition:
- Package score_pkg: command code localparams (CMD_PLAY, CMD_PAUSE, CMD_STOP, CMD_NEXT, CMD_SEL_PFX=3'b101, CMD_LOOP), state encoding, note valid-bit index function.
- Sub-module beat_divider (params DIV): inputs clk, reset_n, en, clr; output tick. Replaces the fixed 15-bit counter IP.

Test Plan:
- Reset, DEF_SONG=1, ROM song 1 = notes 0x81,0x82,0x83 then 0x00; PLAY, BEAT_DIV=4 -> rom_addr 0x20,0x21,0x22; note_out 0x81/0x82/0x83, each for 4 cycles, 2-cycle lag; song_end at step 3; then IDLE, note_out=0.
- Same as above with LOOP_TOGGLE first -> after song_end, rom_addr returns to 0x20 and 0x81 replays; playing stays 1.
- PLAY, PAUSE at step 2 mid-beat, wait 20 cycles, PLAY -> step_dbg holds 2; remaining beat cycles identical to uninterrupted run.
- In PLAY issue SEL 3 (10111) -> IDLE, rom_addr 0x60, note_out 0 next cycle; NEXT -> rom_addr 0x00 (wrap).
- Song of 32 valid notes -> song_end on final tick of step 31; step wraps to 0; no stray step 0 note when loop_en=0.
- Assert reset_n low mid-play -> all outputs reset asynchronously; song=1, loop_en=0.
